uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver. It is the downstream partner of the team's UART transmitter and uses the same 109-clock bit period. It synchronizes the asynchronous RX line, detects start bits, samples each bit at mid-bit, and presents a parallel byte with a rdy/clr_rdy handshake. It also reports framing errors and overrun errors.

Parameters:
- BAUD_DIV, 109: clocks per bit period; must be ≥ 8.
- HALF_DIV, BAUD_DIV/2 (54): clocks from start-edge detect to the start-bit sample.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- RX, input, 1: serial line; asynchronous; idles high.
- clr_rdy, input, 1: consumer acknowledge; clears rdy and ovr_err.
- rx_data, output, 8: last received byte; LSB was received first.
- rdy, output, 1: a byte is valid and not yet acknowledged.
- frm_err, output, 1: stop bit of the last completed frame sampled 0.
- ovr_err, output, 1: a frame completed while rdy was still 1.

Behaviour:
- Reset values:
  - Synchronizer flops preset to 1.
  - rx_data = 0x00; rdy = 0; frm_err = 0; ovr_err = 0.
  - State = IDLE; baud counter = 0; bit counter = 0.
- Synchronizer:
  - RX passes through 2 flops to give rx_s; a third flop gives rx_s_d.
  - fall = rx_s_d & ~rx_s.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - On fall: load the baud counter with HALF_DIV-1 and go to START. This cycle is t0.
  - A line held low generates no new start; only a falling edge does.
- START:
  - Count down to 0, so the sample is taken at t0+HALF_DIV.
  - If rx_s==1 (glitch or false start): go to IDLE; no outputs change.
  - Otherwise: reload BAUD_DIV-1, clear the bit counter, go to DATA.
- DATA:
  - Sample bit i at t0+HALF_DIV+(i+1)*BAUD_DIV, for i = 0..7.
  - Shift right into an 8-bit register, new bit entering at MSB, so bit0 ends at LSB.
  - After the 8th sample, reload the counter and go to STOP.
- STOP:
  - Sample at t0+HALF_DIV+9*BAUD_DIV (t0+1035 with defaults).
  - On that edge: rx_data <= shift register; frm_err <= ~sample.
  - On the next clock edge rdy = 1.
  - The state returns to IDLE in the sample cycle, i.e. mid stop bit, so back-to-back frames are accepted.
  - The byte is delivered even when frm_err = 1.
- Overrun: if rdy==1 and clr_rdy==0 at completion, set ovr_err = 1 and overwrite rx_data.
- clr_rdy with no completion in the same cycle: next cycle rdy = 0 and ovr_err = 0. frm_err is held until the next completion.
- clr_rdy in the same cycle as a completion: completion wins. rdy stays 1, ovr_err stays 0, rx_data takes the new byte.
- Counters:
  - Baud counter is ceil(log2(BAUD_DIV)) bits wide, counting down; it never wraps in normal operation.
  - Bit counter is 4 bits.
- Reset mid-frame: all state returns to reset values immediately; the partial byte is discarded.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined: each start, data and stop decision is the 2-of-3 majority of rx_s sampled at the nominal sample cycle -1, 0 and +1.
  - The decision is registered at nominal+1.
  - All output timing shifts by +1 clock; rdy is set at t0+HALF_DIV+9*BAUD_DIV+2.
- When undefined: single sample at the nominal cycle, as specified above.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Localparams: UART_BAUD_DIV = 109, UART_DATA_BITS = 8.
- Sub-module uart_rx_sync: 2-flop synchronizer, preset-to-1 flops, delayed copy and fall output.
- FSM, counters, shift register and the 3-sample majority logic stay in uart_rx.

Test Plan:
- Drive 0xA5 at 109 clk/bit, 8N1 -> rdy rises exactly 1036 clocks after t0; rx_data=0xA5; frm_err=0; ovr_err=0.
- 30-clock low pulse on an idle line -> false start rejected at the START sample; rdy, rx_data and the flags stay unchanged; the next valid frame 0x3C is received correctly.
- Frame 0x0F with stop bit driven 0, line then returned high -> rdy=1, rx_data=0x0F, frm_err=1. The next good frame 0x81 clears frm_err.
- Frames 0x11 then 0x22 back-to-back with no clr_rdy -> after the 2nd frame rx_data=0x22, ovr_err=1. Pulsing clr_rdy then gives rdy=0, ovr_err=0.
- clr_rdy asserted in the exact completion cycle of frame 0x55 -> rdy remains 1, ovr_err=0, rx_data=0x55.
- rst_n pulsed low during bit 4 of frame 0xFF -> all outputs at reset values. A following frame 0x42 is received correctly.
- With UART_RX_MAJORITY_EN: a 1-clock glitch placed on the bit-3 sample point of 0x00 is filtered (rx_data=0x00), and rdy is set 1 clock later than without the macro.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver slice.
//   - UART_BAUD_DIV  : clocks per bit, matches the UART transmitter.
//   - UART_DATA_BITS : payload width of one frame (8N1).
//   - rx_state_t     : receiver FSM states.
//   - maj3()         : 2-of-3 majority vote used when the optional
//                      UART_RX_MAJORITY_EN sampling mode is compiled in.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BAUD_DIV  = 109;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Majority of three line samples; rejects any single-sample glitch.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous RX line into the clk domain and flags falling edges.
// All flops preset to 1 so a released reset on an idle line never looks like
// a start edge.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   rx_i   in  raw asynchronous serial line
//   rx_s   out synchronized line (two flops after rx_i)
//   fall   out rx_s went 1 -> 0 (delayed copy high, current low)
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Next-state of the synchronizer chain and its delayed copy.
    always_comb begin
        meta_d = rx_i;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Synchronizer and edge-detect flops, preset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rx_s = sync_q;
    assign fall = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, downstream partner of the team UART transmitter.
// Detects a start edge, samples every bit at mid-bit, and hands the byte to
// the consumer through a rdy/clr_rdy handshake with framing and overrun flags.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   When defined, every start/data/stop decision is the 2-of-3 majority of
//   the synchronized line one cycle before, at, and one cycle after the
//   nominal sample point; all output timing moves one clock later.
//
// Parameters:
//   BAUD_DIV  clocks per bit period (>= 8)
//   HALF_DIV  clocks from start-edge detect to the start-bit sample
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   RX       in  asynchronous serial line, idles high
//   clr_rdy  in  consumer acknowledge, clears rdy and ovr_err
//   rx_data  out last received byte (first received bit in the LSB)
//   rdy      out byte valid and not yet acknowledged
//   frm_err  out stop bit of the last completed frame sampled low
//   ovr_err  out a frame completed while rdy was still set
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RX,
    input  logic                      clr_rdy,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rdy,
    output logic                      frm_err,
    output logic                      ovr_err
);

    localparam int CNT_W = $clog2(BAUD_DIV);

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal one, so decide a cycle late.
    localparam int SAMPLE_DLY = 1;
`else
    localparam int SAMPLE_DLY = 0;
`endif

    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(HALF_DIV - 1 + SAMPLE_DLY);
    localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [3:0]       LAST_BIT   = 4'(UART_DATA_BITS - 1);

    logic rx_s;
    logic fall_s;
    logic samp_s;
    logic baud_zero_s;
    logic done_s;

    rx_state_t                 state_q,    state_d;
    logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
    logic [3:0]                bit_cnt_q,  bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q,    shift_d;
    logic [UART_DATA_BITS-1:0] rx_data_q,  rx_data_d;
    logic                      rdy_q,      rdy_d;
    logic                      frm_err_q,  frm_err_d;
    logic                      ovr_err_q,  ovr_err_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_i  (RX),
        .rx_s  (rx_s),
        .fall  (fall_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
    logic [1:0] hist_q, hist_d;

    // Line history feeding the majority vote.
    always_comb begin
        hist_d = {hist_q[0], rx_s};
        samp_s = maj3(hist_q[1], hist_q[0], rx_s);
    end

    // History register, preset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign samp_s = rx_s;
`endif

    assign baud_zero_s = (baud_cnt_q == CNT_ZERO);

    // Frame FSM: counters, shift register and completion detect.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        frm_err_d  = frm_err_q;
        done_s     = 1'b0;

        case (state_q)
            IDLE: begin
                // Only an edge starts a frame; a stuck-low line stays here.
                if (fall_s) begin
                    baud_cnt_d = START_LOAD;
                    state_d    = START;
                end else begin
                    baud_cnt_d = baud_cnt_q;
                end
            end
            START: begin
                if (!baud_zero_s) begin
                    baud_cnt_d = baud_cnt_q - CNT_ONE;
                end else if (samp_s) begin
                    // Line back high at mid start bit: false start, drop it.
                    state_d = IDLE;
                end else begin
                    baud_cnt_d = BIT_LOAD;
                    bit_cnt_d  = 4'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (!baud_zero_s) begin
                    baud_cnt_d = baud_cnt_q - CNT_ONE;
                end else begin
                    // LSB arrives first, so shift right with the new bit at MSB.
                    shift_d    = {samp_s, shift_q[UART_DATA_BITS-1:1]};
                    baud_cnt_d = BIT_LOAD;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            STOP: begin
                if (!baud_zero_s) begin
                    baud_cnt_d = baud_cnt_q - CNT_ONE;
                end else begin
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    done_s    = 1'b1;
                    rx_data_d = shift_q;
                    frm_err_d = ~samp_s;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Consumer handshake: a completing frame takes priority over clr_rdy.
    always_comb begin
        rdy_d     = rdy_q;
        ovr_err_d = ovr_err_q;
        if (done_s) begin
            rdy_d     = 1'b1;
            ovr_err_d = rdy_q & ~clr_rdy;
        end else if (clr_rdy) begin
            rdy_d     = 1'b0;
            ovr_err_d = 1'b0;
        end else begin
            rdy_d     = rdy_q;
            ovr_err_d = ovr_err_q;
        end
    end

    // State, counter, data and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= CNT_ZERO;
            bit_cnt_q  <= 4'd0;
            shift_q    <= {UART_DATA_BITS{1'b0}};
            rx_data_q  <= {UART_DATA_BITS{1'b0}};
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Drives serial frames onto RX and compares every cycle's outputs with a
// frame-level model: each transmitted frame is reduced to "at cycle N a byte
// with this stop bit completes", and the handshake rules are applied there.
// ---------------------------------------------------------------------------
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int BIT = 109;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       RX      = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    uart_rx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pending frame completion, written by the stimulus.
    int         pend_cycle = -1;
    logic [7:0] pend_byte  = 8'h00;
    logic       pend_stop  = 1'b1;
    logic       pend_valid = 1'b0;

    // Model outputs.
    logic [7:0] exp_data = 8'h00;
    logic       exp_rdy  = 1'b0;
    logic       exp_frm  = 1'b0;
    logic       exp_ovr  = 1'b0;

    // Frame-level model: apply completion or acknowledge at the end of a cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data <= 8'h00;
            exp_rdy  <= 1'b0;
            exp_frm  <= 1'b0;
            exp_ovr  <= 1'b0;
        end else if (pend_valid && pend_cycle == cyc) begin
            exp_ovr  <= exp_rdy && !clr_rdy;
            exp_rdy  <= 1'b1;
            exp_data <= pend_byte;
            exp_frm  <= !pend_stop;
        end else if (clr_rdy) begin
            exp_rdy <= 1'b0;
            exp_ovr <= 1'b0;
        end
    end

    int   n_checks = 0;
    int   n_pass   = 0;
    int   rise_cyc = -1;
    int   last_c   = 0;
    logic rdy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        check("outputs{rdy,frm,ovr,data}", {21'd0, rdy, frm_err, ovr_err, rx_data},
              {21'd0, exp_rdy, exp_frm, exp_ovr, exp_data});
        if (rdy && !rdy_prev) rise_cyc = cyc;
        rdy_prev = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
        tick();
    endtask

    // Transmit one 8N1 frame. rst_bit / glitch_bit < 0 disable those options.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_bit,
                              input int glitch_bit, input logic clr_at_comp);
        logic [7:0] exp_b;
        exp_b = b;
        // Without voting the receiver takes whatever is on the line at mid-bit.
        if (glitch_bit >= 0 && MAJ == 0) exp_b[3'(glitch_bit)] = ~b[3'(glitch_bit)];
        last_c     = cyc;
        rise_cyc   = -1;
        pend_byte  = exp_b;
        pend_stop  = stop_bit;
        // Start edge reaches the FSM 2 cycles later (t0); completion at t0+1035.
        pend_cycle = cyc + 2 + 1035 + MAJ;
        pend_valid = (rst_bit < 0);
        RX = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 8; i++) begin
            RX = b[3'(i)];
            if (i == rst_bit) begin
                repeat (50) tick();
                rst_n      = 1'b0;
                pend_valid = 1'b0;
                repeat (3) tick();
                rst_n = 1'b1;
                repeat (56) tick();
            end else if (i == glitch_bit) begin
                repeat (54) tick();
                RX = ~b[3'(i)];
                tick();
                RX = b[3'(i)];
                repeat (54) tick();
            end else begin
                repeat (BIT) tick();
            end
        end
        RX = stop_bit;
        for (int k = 0; k < BIT; k++) begin
            if (clr_at_comp) clr_rdy = (cyc == pend_cycle);
            tick();
        end
        clr_rdy = 1'b0;
        RX      = 1'b1;
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_data", {24'd0, rx_data}, 32'h00);
        check("reset_flags", {30'd0, frm_err, ovr_err}, 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();

        // Basic frame and exact rdy latency.
        send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
        check("a5_latency", rise_cyc - (last_c + 2), 1036 + MAJ);
        check("a5_data", {24'd0, rx_data}, 32'hA5);
        check("a5_flags", {29'd0, rdy, frm_err, ovr_err}, 32'b100);
        pulse_clr();

        // False start: 30-clock low pulse.
        RX = 1'b0;
        repeat (30) tick();
        RX = 1'b1;
        repeat (200) tick();
        check("false_start", {23'd0, rdy, rx_data}, {23'd0, 1'b0, 8'hA5});
        send_frame(8'h3C, 1'b1, -1, -1, 1'b0);
        check("3c_latency", rise_cyc - (last_c + 2), 1036 + MAJ);
        check("3c_data", {24'd0, rx_data}, 32'h3C);
        pulse_clr();

        // Framing error, then cleared by a good frame.
        send_frame(8'h0F, 1'b0, -1, -1, 1'b0);
        repeat (20) tick();
        check("frm_data", {24'd0, rx_data}, 32'h0F);
        check("frm_flags", {29'd0, rdy, frm_err, ovr_err}, 32'b110);
        pulse_clr();
        check("frm_held", {31'd0, frm_err}, 32'd1);
        send_frame(8'h81, 1'b1, -1, -1, 1'b0);
        check("81_frm_clear", {23'd0, frm_err, rx_data}, {23'd0, 1'b0, 8'h81});
        pulse_clr();

        // Overrun with back-to-back frames.
        send_frame(8'h11, 1'b1, -1, -1, 1'b0);
        send_frame(8'h22, 1'b1, -1, -1, 1'b0);
        check("ovr_data", {24'd0, rx_data}, 32'h22);
        check("ovr_flags", {29'd0, rdy, frm_err, ovr_err}, 32'b101);
        pulse_clr();
        check("ovr_cleared", {30'd0, rdy, ovr_err}, 32'd0);

        // clr_rdy in the completion cycle loses to the completion.
        send_frame(8'h33, 1'b1, -1, -1, 1'b0);
        send_frame(8'h55, 1'b1, -1, -1, 1'b1);
        check("clr_race", {23'd0, rdy, ovr_err, rx_data}, {23'd0, 2'b10, 8'h55});
        pulse_clr();

        // Reset in the middle of bit 4.
        send_frame(8'hFF, 1'b1, 4, -1, 1'b0);
        check("midrst", {21'd0, rdy, frm_err, ovr_err, rx_data}, 32'd0);
        send_frame(8'h42, 1'b1, -1, -1, 1'b0);
        check("42_data", {23'd0, rdy, rx_data}, {23'd0, 1'b1, 8'h42});
        pulse_clr();

        // One-clock glitch on the bit-3 sample point of 0x00.
        send_frame(8'h00, 1'b1, -1, 3, 1'b0);
        check("glitch_data", {24'd0, rx_data}, (MAJ != 0) ? 32'h00 : 32'h08);
        check("glitch_latency", rise_cyc - (last_c + 2), 1036 + MAJ);

        // Randomized frames, gaps, stop bits and acknowledges.
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 1) == 1) pulse_clr();
            repeat ($urandom_range(0, 150)) tick();
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0), -1, -1, 1'b0);
        end
        repeat (200) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
